// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation sequencing logic.
package gol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQUEST,
    COUNT,
    HALTED
  } sched_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // 660 ms per generation at a 50 MHz system clock.
  localparam int TICK_DIV = 33_000_000;

  // Next value of a single BCD digit; 9 rolls over to 0 and the caller handles the carry.
  function automatic bcd_digit_t bcdNext(input bcd_digit_t digit);
    return (digit == BCD_NINE) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/generation_tick_divider.sv
// Generation tick counter. Counts 0..TICK_DIV-1 while enabled and flags the
// terminal count. The synchronous clear lets the scheduler phase-align ticks
// to the moment the game is started.
module generation_tick_divider
  import gol_pkg::*;
#(
  parameter int DIV = TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tickDone
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] tickCount;

  // Tick counter: held at zero while cleared, wraps on terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tickCount <= '0;
    end else if (clear) begin
      tickCount <= '0;
    end else if (enable) begin
      tickCount <= (tickCount == LAST_COUNT) ? '0 : tickCount + 1'b1;
    end
  end

  assign tickDone = enable && !clear && (tickCount == LAST_COUNT);

endmodule

// File: rtl/generation_scheduler.sv
// Generation loop sequencer: paces generations, handshakes each board update,
// keeps the BCD generation count and drives the digit increment pulses.
module generation_scheduler
  import gol_pkg::*;
#(
  parameter int          TICK_DIV = gol_pkg::TICK_DIV,
  parameter logic [11:0] MAX_GEN  = 12'h999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startGameSwitch,
  input  logic        stepButton,
  input  logic        clearButton,
  input  logic        boardDone,
  input  logic        boardStable,
  output logic        genRequest,
  output logic        onesInc,
  output logic        tensInc,
  output logic        hundredsInc,
  output logic [11:0] genCount,
  output logic        running,
  output logic        halted
);

  sched_state_t state, nextState;
  logic [11:0]  countNext;
  logic         genRequestNext, onesIncNext, tensIncNext, hundredsIncNext;
  logic         runningNext, haltedNext;
  logic         tickDone, tickClear, tickEnable;
  bcd_digit_t   onesDigit, tensDigit, hundredsDigit;

  assign onesDigit     = genCount[3:0];
  assign tensDigit     = genCount[7:4];
  assign hundredsDigit = genCount[11:8];

  // The tick counter only runs in WAIT_TICK, so every wait starts from zero.
  assign tickEnable = (state == WAIT_TICK);
  assign tickClear  = (state != WAIT_TICK);

  generation_tick_divider #(
    .DIV(TICK_DIV)
  ) tickDivider (
    .clk     (clk),
    .reset   (reset),
    .clear   (tickClear),
    .enable  (tickEnable),
    .tickDone(tickDone)
  );

  // State, count and all outputs are registered so every output is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      genCount    <= 12'h000;
      genRequest  <= 1'b0;
      onesInc     <= 1'b0;
      tensInc     <= 1'b0;
      hundredsInc <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= nextState;
      genCount    <= countNext;
      genRequest  <= genRequestNext;
      onesInc     <= onesIncNext;
      tensInc     <= tensIncNext;
      hundredsInc <= hundredsIncNext;
      running     <= runningNext;
      halted      <= haltedNext;
    end
  end

  // Next state, next count and next output values; the increment is applied on
  // the edge that accepts boardDone so COUNT already shows the new count.
  always_comb begin
    nextState       = state;
    countNext       = genCount;
    onesIncNext     = 1'b0;
    tensIncNext     = 1'b0;
    hundredsIncNext = 1'b0;

    case (state)
      IDLE: begin
        if (clearButton) begin
          countNext = 12'h000;
        end else if (stepButton) begin
          nextState = REQUEST;
        end else if (startGameSwitch) begin
          nextState = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (clearButton || !startGameSwitch) begin
          nextState = IDLE;
          if (clearButton) begin
            countNext = 12'h000;
          end
        end else if (tickDone) begin
          nextState = REQUEST;
        end
      end

      REQUEST: begin
        if (boardDone) begin
          nextState       = COUNT;
          onesIncNext     = 1'b1;
          tensIncNext     = (onesDigit == BCD_NINE);
          hundredsIncNext = (onesDigit == BCD_NINE) && (tensDigit == BCD_NINE);
          countNext[3:0]  = bcdNext(onesDigit);
          if (tensIncNext) begin
            countNext[7:4] = bcdNext(tensDigit);
          end
          if (hundredsIncNext) begin
            countNext[11:8] = bcdNext(hundredsDigit);
          end
        end
      end

      COUNT: begin
        if ((genCount == MAX_GEN) || boardStable) begin
          nextState = HALTED;
        end else if (startGameSwitch) begin
          nextState = WAIT_TICK;
        end else begin
          nextState = IDLE;
        end
      end

      HALTED: begin
        if (clearButton) begin
          nextState = IDLE;
          countNext = 12'h000;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase

    genRequestNext = (nextState == REQUEST);
    runningNext    = (nextState == WAIT_TICK) || (nextState == REQUEST) || (nextState == COUNT);
    haltedNext     = (nextState == HALTED);
  end

endmodule

// File: tb/tb_generation_scheduler.sv
// Testbench for generation_scheduler: a randomized board responder feeds a
// scoreboard of expected counts computed from a plain generation number.
module tb_generation_scheduler;

  localparam int          TICK_DIV = 4;
  localparam logic [11:0] MAX_GEN  = 12'h105;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startGameSwitch = 1'b0;
  logic        stepButton = 1'b0;
  logic        clearButton = 1'b0;
  logic        boardDone = 1'b0;
  logic        boardStable = 1'b0;
  logic        genRequest;
  logic        onesInc;
  logic        tensInc;
  logic        hundredsInc;
  logic [11:0] genCount;
  logic        running;
  logic        halted;

  typedef struct packed {
    logic [11:0] count;
    logic        tens;
    logic        hundreds;
  } expect_t;

  expect_t expQ[$];
  expect_t monExp;
  int      assertCount = 0;
  int      failCount = 0;
  int      genNum = 0;
  int      reqRises = 0;
  int      boardLat = 0;
  int      rises0 = 0;
  int      cycles = 0;
  bit      autoBoard = 1'b0;
  logic    prevReq = 1'b0;

  generation_scheduler #(
    .TICK_DIV(TICK_DIV),
    .MAX_GEN (MAX_GEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startGameSwitch(startGameSwitch),
    .stepButton     (stepButton),
    .clearButton    (clearButton),
    .boardDone      (boardDone),
    .boardStable    (boardStable),
    .genRequest     (genRequest),
    .onesInc        (onesInc),
    .tensInc        (tensInc),
    .hundredsInc    (hundredsInc),
    .genCount       (genCount),
    .running        (running),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Decimal generation number to the BCD display value.
  function automatic logic [11:0] toBcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string what);
    if (what == "step") stepButton = 1'b1;
    else if (what == "clear") clearButton = 1'b1;
    @(negedge clk);
    stepButton  = 1'b0;
    clearButton = 1'b0;
  endtask

  task automatic waitRunningLow(input string name);
    int c = 0;
    while (running && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (running) checkOutput(name, 12'(running), 12'h0);
  endtask

  task automatic waitHalted(input string name);
    int c = 0;
    while (!halted && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!halted) checkOutput(name, 12'(halted), 12'h1);
  endtask

  // Board model: answers each request after a random latency and records the
  // generation that this handshake completes.
  always begin
    @(negedge clk);
    if (autoBoard && genRequest) begin
      boardLat = $urandom_range(0, 3);
      repeat (boardLat) @(negedge clk);
      boardDone = 1'b1;
      genNum++;
      expQ.push_back('{toBcd(genNum), (genNum % 10) == 0, (genNum % 100) == 0});
      @(negedge clk);
      boardDone = 1'b0;
    end
  end

  // Monitor: every increment pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (genRequest && !prevReq) reqRises++;
    prevReq = genRequest;
    if (onesInc) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedIncrement", 12'(onesInc), 12'h0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("genCount", genCount, monExp.count);
        checkOutput("tensInc", 12'(tensInc), 12'(monExp.tens));
        checkOutput("hundredsInc", 12'(hundredsInc), 12'(monExp.hundreds));
      end
    end else if (tensInc || hundredsInc) begin
      checkOutput("strayCarryPulse", 12'({tensInc, hundredsInc}), 12'h0);
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("resetCount", genCount, 12'h000);
    checkOutput("resetRequest", 12'(genRequest), 12'h0);
    checkOutput("resetRunning", 12'(running), 12'h0);
    checkOutput("resetHalted", 12'(halted), 12'h0);
    checkOutput("resetIncs", 12'({onesInc, tensInc, hundredsInc}), 12'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleRunning", 12'(running), 12'h0);
    checkOutput("idleRequest", 12'(genRequest), 12'h0);

    // Free run from 000 up to the MAX_GEN halt
    autoBoard = 1'b1;
    startGameSwitch = 1'b1;
    @(negedge clk);
    checkOutput("startToWaitTick", 12'(running), 12'h1);
    cycles = 0;
    while (!genRequest && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("tickLatency", 12'(cycles), 12'(TICK_DIV));
    waitHalted("maxGenHaltTimeout");
    checkOutput("maxGenCount", genCount, 12'h105);
    checkOutput("maxGenModel", toBcd(genNum), 12'h105);
    checkOutput("haltedRunning", 12'(running), 12'h0);

    // HALTED ignores start and step
    applyStimulus("step");
    repeat (10) @(negedge clk);
    checkOutput("haltHold", 12'(halted), 12'h1);
    checkOutput("haltHoldCount", genCount, 12'h105);
    checkOutput("haltNoRequest", 12'(genRequest), 12'h0);
    startGameSwitch = 1'b0;
    genNum = 0;
    applyStimulus("clear");
    checkOutput("clearCount", genCount, 12'h000);
    checkOutput("clearHalted", 12'(halted), 12'h0);

    // Single step from IDLE
    rises0 = reqRises;
    applyStimulus("step");
    checkOutput("stepRequest", 12'(genRequest), 12'h1);
    waitRunningLow("stepDoneTimeout");
    repeat (10) @(negedge clk);
    checkOutput("stepRequestCount", 12'(reqRises - rises0), 12'h1);
    checkOutput("stepCount", genCount, 12'h001);
    checkOutput("stepBackIdle", 12'(running), 12'h0);

    // Step ignored in WAIT_TICK; start dropped during REQUEST
    startGameSwitch = 1'b1;
    @(negedge clk);
    applyStimulus("step");
    checkOutput("stepInWaitTick", 12'(genRequest), 12'h0);
    cycles = 0;
    while (!genRequest && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    startGameSwitch = 1'b0;
    waitRunningLow("dropStartTimeout");
    repeat (10) @(negedge clk);
    checkOutput("dropStartCount", genCount, 12'h002);
    checkOutput("dropStartIdle", 12'(running), 12'h0);

    // Stable board halts the run
    startGameSwitch = 1'b1;
    cycles = 0;
    while (!(genCount == 12'h007 && !onesInc && running) && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    boardStable = 1'b1;
    waitHalted("stableHaltTimeout");
    checkOutput("stableCount", genCount, 12'h008);
    applyStimulus("step");
    repeat (10) @(negedge clk);
    checkOutput("stableHold", 12'(halted), 12'h1);
    checkOutput("stableHoldCount", genCount, 12'h008);
    boardStable = 1'b0;
    startGameSwitch = 1'b0;
    genNum = 0;
    applyStimulus("clear");
    checkOutput("stableClearCount", genCount, 12'h000);
    checkOutput("stableClearHalted", 12'(halted), 12'h0);

    // Reset in the middle of a handshake
    applyStimulus("step");
    waitRunningLow("preAbortTimeout");
    repeat (4) @(negedge clk);
    checkOutput("preAbortCount", genCount, 12'h001);
    autoBoard = 1'b0;
    applyStimulus("step");
    checkOutput("abortRequestUp", 12'(genRequest), 12'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abortRequestDrop", 12'(genRequest), 12'h0);
    checkOutput("abortCount", genCount, 12'h000);
    genNum = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    boardDone = 1'b1;
    @(negedge clk);
    boardDone = 1'b0;
    checkOutput("lateDoneInc", 12'(onesInc), 12'h0);
    checkOutput("lateDoneCount", genCount, 12'h000);
    checkOutput("lateDoneRunning", 12'(running), 12'h0);
    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 12'(expQ.size()), 12'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
